bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double-dabble, one bit per clock).
// Optional two's-complement input: the magnitude is converted and the sign is reported on neg.
module bin2bcd_seq #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic        neg,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [19:0] scratch, scratch_n;
    logic [15:0] mag, mag_n;
    logic        sign, sign_n;
    logic        busy_n, done_n, neg_n;
    logic [19:0] digits, digits_n;
    logic [19:0] adj;
    logic [19:0] shifted;
    logic [15:0] negated;
    logic        take_neg;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // 0x8000 negates to itself, which read as unsigned is the required 32768.
    assign negated  = ~bin + 16'd1;
    assign take_neg = SIGNED && bin[15];

    assign adj     = {add3(scratch[19:16]), add3(scratch[15:12]), add3(scratch[11:8]),
                      add3(scratch[7:4]),   add3(scratch[3:0])};
    assign shifted = {adj[18:0], mag[15]};

    assign d0 = digits[19:16];
    assign d1 = digits[15:12];
    assign d2 = digits[11:8];
    assign d3 = digits[7:4];
    assign d4 = digits[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            scratch <= '0;
            mag     <= '0;
            sign    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            digits  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            scratch <= scratch_n;
            mag     <= mag_n;
            sign    <= sign_n;
            busy    <= busy_n;
            done    <= done_n;
            neg     <= neg_n;
            digits  <= digits_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        scratch_n = scratch;
        mag_n     = mag;
        sign_n    = sign;
        busy_n    = busy;
        done_n    = 1'b0;
        neg_n     = neg;
        digits_n  = digits;

        case (state)
            IDLE: begin
                if (start) begin
                    mag_n     = take_neg ? negated : bin;
                    sign_n    = take_neg;
                    scratch_n = '0;
                    cnt_n     = '0;
                    busy_n    = 1'b1;
                    state_n   = CONV;
                end
            end
            CONV: begin
                scratch_n = shifted;
                mag_n     = {mag[14:0], 1'b0};
                cnt_n     = cnt + 5'd1;
                // Sixteenth iteration: publish the freshly shifted result directly.
                if (cnt == 5'd15) begin
                    cnt_n    = '0;
                    state_n  = IDLE;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    digits_n = shifted;
                    neg_n    = sign && (shifted != '0);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: one signed and one unsigned instance share all inputs
// and are checked against hand-computed digits and a decimal division model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin;

    logic        s_busy, s_done, s_neg;
    logic [3:0]  s_d0, s_d1, s_d2, s_d3, s_d4;
    logic        u_busy, u_done, u_neg;
    logic [3:0]  u_d0, u_d1, u_d2, u_d3, u_d4;
    logic [20:0] s_res, u_res;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(s_busy), .done(s_done), .neg(s_neg),
        .d0(s_d0), .d1(s_d1), .d2(s_d2), .d3(s_d3), .d4(s_d4)
    );

    bin2bcd_seq #(.SIGNED(1'b0)) u_u (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(u_busy), .done(u_done), .neg(u_neg),
        .d0(u_d0), .d1(u_d1), .d2(u_d2), .d3(u_d3), .d4(u_d4)
    );

    assign s_res = {s_neg, s_d0, s_d1, s_d2, s_d3, s_d4};
    assign u_res = {u_neg, u_d0, u_d1, u_d2, u_d3, u_d4};

    // Decimal reference: {neg, d0..d4} by division, independent of double-dabble.
    function automatic logic [20:0] ref_model(input logic [15:0] b, input bit sgn);
        int m;
        logic [19:0] d;
        m = (sgn && b[15]) ? 65536 - int'(b) : int'(b);
        d[19:16] = 4'(m / 10000);
        d[15:12] = 4'((m / 1000) % 10);
        d[11:8]  = 4'((m / 100) % 10);
        d[7:4]   = 4'((m / 10) % 10);
        d[3:0]   = 4'(m % 10);
        return {(sgn && b[15] && m != 0), d};
    endfunction

    // Called at a negedge; start is seen by the following rising edge.
    task automatic pulse_start(input logic [15:0] v);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int k, output bit overlap);
        k = 0;
        overlap = 1'b0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if ((s_busy && s_done) || (u_busy && u_done)) overlap = 1'b1;
            if (s_done) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bin = '0;
        #1;
        vectors++;
        if ({s_busy, s_done, s_res} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_signed: got %h expected 0", {s_busy, s_done, s_res});
        end
        vectors++;
        if ({u_busy, u_done, u_res} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_unsigned: got %h expected 0", {u_busy, u_done, u_res});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int k; bit ov;
        @(negedge clk);
        pulse_start(16'h3039);
        vectors++;
        if ({s_busy, s_done} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_busy: got %b expected 10", {s_busy, s_done});
        end
        wait_done(k, ov);
        vectors++;
        if (k !== 16) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d expected 16", k);
        end
        vectors++;
        if (s_res !== {1'b0, 20'h12345}) begin
            miscompares++;
            $display("FAIL basic_signed: got %h expected %h", s_res, {1'b0, 20'h12345});
        end
        vectors++;
        if (u_res !== {1'b0, 20'h12345}) begin
            miscompares++;
            $display("FAIL basic_unsigned: got %h expected %h", u_res, {1'b0, 20'h12345});
        end
        vectors++;
        if (ov !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_overlap: got %b expected 0", ov);
        end
        @(negedge clk);
        vectors++;
        if ({s_busy, s_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_done_width: got %b expected 00", {s_busy, s_done});
        end
    endtask

    task automatic test_signed_edges;
        int k; bit ov; bit held;
        @(negedge clk);
        pulse_start(16'hFFFF);
        wait_done(k, ov);
        vectors++;
        if (s_res !== {1'b1, 20'h00001}) begin
            miscompares++;
            $display("FAIL ffff_signed: got %h expected %h", s_res, {1'b1, 20'h00001});
        end
        vectors++;
        if (u_res !== {1'b0, 20'h65535}) begin
            miscompares++;
            $display("FAIL ffff_unsigned: got %h expected %h", u_res, {1'b0, 20'h65535});
        end
        // Outputs must hold the -1 result for the whole 0x8000 conversion.
        @(negedge clk);
        pulse_start(16'h8000);
        held = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (s_res !== {1'b1, 20'h00001} || s_done !== 1'b0) held = 1'b0;
        end
        vectors++;
        if (held !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_during_conv: got %b expected 1", held);
        end
        @(negedge clk);
        vectors++;
        if (s_done !== 1'b1) begin
            miscompares++;
            $display("FAIL 8000_done_at_16: got %b expected 1", s_done);
        end
        vectors++;
        if (s_res !== {1'b1, 20'h32768}) begin
            miscompares++;
            $display("FAIL 8000_signed: got %h expected %h", s_res, {1'b1, 20'h32768});
        end
        vectors++;
        if (u_res !== {1'b0, 20'h32768}) begin
            miscompares++;
            $display("FAIL 8000_unsigned: got %h expected %h", u_res, {1'b0, 20'h32768});
        end
    endtask

    task automatic test_zero;
        int k; bit ov;
        @(negedge clk);
        pulse_start(16'h0000);
        wait_done(k, ov);
        vectors++;
        if (s_res !== 21'd0 || u_res !== 21'd0) begin
            miscompares++;
            $display("FAIL zero: got %h/%h expected 0/0", s_res, u_res);
        end
    endtask

    task automatic test_ignore_start;
        int k; int pulses; int first_k;
        @(negedge clk);
        pulse_start(16'h0064);
        k = 0;
        repeat (4) @(negedge clk);
        pulse_start(16'h0001);
        k = 5;
        pulses = 0;
        first_k = 0;
        while (k < 45) begin
            @(negedge clk);
            k++;
            if (s_done) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL ignore_pulses: got %0d expected 1", pulses);
        end
        vectors++;
        if (first_k !== 16) begin
            miscompares++;
            $display("FAIL ignore_latency: got %0d expected 16", first_k);
        end
        vectors++;
        if (s_res !== {1'b0, 20'h00100}) begin
            miscompares++;
            $display("FAIL ignore_result: got %h expected %h", s_res, {1'b0, 20'h00100});
        end
    endtask

    task automatic test_abort;
        int k; bit ov; int pulses;
        @(negedge clk);
        pulse_start(16'h270F);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({s_busy, s_done, s_res, u_busy, u_done, u_res} !== 46'd0) begin
            miscompares++;
            $display("FAIL abort_async: got %h expected 0",
                     {s_busy, s_done, s_res, u_busy, u_done, u_res});
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_done || u_done) pulses++;
        end
        vectors++;
        if (pulses !== 0 || s_res !== 21'd0) begin
            miscompares++;
            $display("FAIL abort_no_done: got pulses=%0d res=%h expected 0/0", pulses, s_res);
        end
        // Start in the same cycle reset falls: accepted on the first edge with rst low.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start(16'h270F);
        wait_done(k, ov);
        vectors++;
        if (k !== 16) begin
            miscompares++;
            $display("FAIL post_reset_latency: got %0d expected 16", k);
        end
        vectors++;
        if (s_res !== {1'b0, 20'h09999}) begin
            miscompares++;
            $display("FAIL post_reset_result: got %h expected %h", s_res, {1'b0, 20'h09999});
        end
    endtask

    task automatic test_back_to_back;
        int k; bit ov;
        logic [15:0] v;
        logic [15:0] list [17] = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999,
                                   16'd1000, 16'd9999, 16'd10000, 16'h7FFF, 16'h8000,
                                   16'h8001, 16'hFFFE, 16'hFFFF, 16'hD8F1, 16'hC350};
        @(negedge clk);
        pulse_start(16'd4242);
        wait_done(k, ov);
        for (int i = 0; i < 17 + 150; i++) begin
            v = (i < 17) ? list[i] : 16'($urandom);
            pulse_start(v);
            wait_done(k, ov);
            vectors++;
            if (k !== 16 || ov !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_timing[%0d]: got k=%0d ov=%b expected k=16 ov=0", i, k, ov);
            end
            vectors++;
            if (s_res !== ref_model(v, 1'b1)) begin
                miscompares++;
                $display("FAIL b2b_signed[%h]: got %h expected %h", v, s_res, ref_model(v, 1'b1));
            end
            vectors++;
            if (u_res !== ref_model(v, 1'b0)) begin
                miscompares++;
                $display("FAIL b2b_unsigned[%h]: got %h expected %h", v, u_res, ref_model(v, 1'b0));
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed_edges;
        test_zero;
        test_ignore_start;
        test_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
